// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared state encodings and constants for the pipeline control block
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERR      = 2'b10
  } ctrl_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Load in EX whose result the instruction in ID needs before forwarding can supply it.
  function automatic logic loadUse(
    input logic [4:0] idRs,
    input logic [4:0] idRt,
    input logic       usesRs,
    input logic       usesRt,
    input logic [4:0] exAw,
    input logic       exRegWr,
    input logic       exMemToReg
  );
    return exMemToReg && exRegWr && (exAw != REG_ZERO) &&
           ((usesRs && (idRs == exAw)) || (usesRt && (idRt == exAw)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter used for the performance counters
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
module pipe_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int MEM_TMO = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic [4:0]       ex_aw,
  input  logic             ex_regwr,
  input  logic             ex_memtoreg,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             memwb_bubble,
  output logic             tmo_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [7:0] TMO_LIMIT = 8'(MEM_TMO);

  ctrl_state_e state;
  logic [7:0]  waitCnt;
  logic        tmoErr;
  logic        lu;
  logic        memPending;

  assign lu         = loadUse(id_rs, id_rt, id_uses_rs, id_uses_rt, ex_aw, ex_regwr, ex_memtoreg);
  assign memPending = mem_req && !mem_ready;
  assign tmo_err    = tmoErr;

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_bubble  = 1'b0;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    memwb_bubble = 1'b0;
    if (reset) begin
      if (state == ST_ERR) begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end else if (memPending) begin
        // Hold everything upstream of MEM; WB keeps draining with a nop behind it.
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        memwb_bubble = 1'b1;
      end else if (lu) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end else if (id_jump) begin
        ifid_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_RUN;
      waitCnt <= 8'd0;
      tmoErr  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (memPending) begin
            state   <= ST_MEM_WAIT;
            waitCnt <= 8'd1;
          end
        end
        ST_MEM_WAIT: begin
          // A dropped request counts as completion, same as mem_ready.
          if (!memPending) begin
            state   <= ST_RUN;
            waitCnt <= 8'd0;
          end else if (waitCnt >= TMO_LIMIT) begin
            state  <= ST_ERR;
            tmoErr <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        ST_ERR: state <= ST_ERR;
        default: state <= ST_RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!pc_en),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ifid_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int CNT_W   = 3;
  localparam int MEM_TMO = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs, id_rt, ex_aw;
  logic             id_uses_rs, id_uses_rt, id_jump;
  logic             ex_regwr, ex_memtoreg, mem_req, mem_ready;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_bubble;
  logic             exmem_en, memwb_en, memwb_bubble, tmo_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TMO(MEM_TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_jump      (id_jump),
    .ex_aw        (ex_aw),
    .ex_regwr     (ex_regwr),
    .ex_memtoreg  (ex_memtoreg),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_en      (idex_en),
    .idex_bubble  (idex_bubble),
    .exmem_en     (exmem_en),
    .memwb_en     (memwb_en),
    .memwb_bubble (memwb_bubble),
    .tmo_err      (tmo_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_bubble, memwb_bubble}
  function automatic logic [7:0] ctl();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble, memwb_bubble};
  endfunction

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_jump = 1'b0;
    ex_aw = 5'd0; ex_regwr = 1'b0; ex_memtoreg = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
  endtask

  task automatic set_load(input logic [4:0] aw);
    ex_memtoreg = 1'b1; ex_regwr = 1'b1; ex_aw = aw;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    #3;
    checks++;
    if (ctl() !== 8'b11111_000) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl(), 8'b11111_000); end
    checks++;
    if ({tmo_err, stall_cnt, flush_cnt} !== 7'd0) begin errors++; $display("FAIL reset_state got tmo=%b st=%0d fl=%0d exp 0", tmo_err, stall_cnt, flush_cnt); end
    step();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_load_use();
    do_reset();
    set_load(5'd5); id_rs = 5'd5; id_uses_rs = 1'b1;
    #2;
    checks++;
    if (ctl() !== 8'b00111_010) begin errors++; $display("FAIL lu_stall got=%b exp=%b", ctl(), 8'b00111_010); end
    step();
    checks++;
    if (stall_cnt !== 3'd1) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
    ex_memtoreg = 1'b0; ex_regwr = 1'b0;
    #2;
    checks++;
    if (ctl() !== 8'b11111_000) begin errors++; $display("FAIL lu_release got=%b exp=%b", ctl(), 8'b11111_000); end
    set_load(5'd0); id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
    #2;
    checks++;
    if (ctl() !== 8'b11111_000) begin errors++; $display("FAIL lu_zero got=%b exp=%b", ctl(), 8'b11111_000); end
    step();
    clear_inputs();
    set_load(5'd9); id_rt = 5'd9; id_uses_rt = 1'b1; id_rs = 5'd9;
    #2;
    checks++;
    if (ctl() !== 8'b00111_010) begin errors++; $display("FAIL lu_rt got=%b exp=%b", ctl(), 8'b00111_010); end
    id_uses_rt = 1'b0;
    #2;
    checks++;
    if (ctl() !== 8'b11111_000) begin errors++; $display("FAIL lu_unused got=%b exp=%b", ctl(), 8'b11111_000); end
    step();
    checks++;
    if (stall_cnt !== 3'd1) begin errors++; $display("FAIL lu_cnt_final got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_jump();
    do_reset();
    id_jump = 1'b1;
    #2;
    checks++;
    if (ctl() !== 8'b11111_100) begin errors++; $display("FAIL jump got=%b exp=%b", ctl(), 8'b11111_100); end
    step();
    checks++;
    if (flush_cnt !== 3'd1) begin errors++; $display("FAIL jump_cnt got=%0d exp=1", flush_cnt); end
    set_load(5'd7); id_rs = 5'd7; id_uses_rs = 1'b1;
    #2;
    checks++;
    if (ctl() !== 8'b00111_010) begin errors++; $display("FAIL jump_lu got=%b exp=%b", ctl(), 8'b00111_010); end
    step();
    ex_memtoreg = 1'b0; ex_regwr = 1'b0;
    #2;
    checks++;
    if (ctl() !== 8'b11111_100) begin errors++; $display("FAIL jump_after_lu got=%b exp=%b", ctl(), 8'b11111_100); end
    step();
    checks++;
    if ({stall_cnt, flush_cnt} !== {3'd1, 3'd2}) begin errors++; $display("FAIL jump_cnts got st=%0d fl=%0d exp st=1 fl=2", stall_cnt, flush_cnt); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    set_load(5'd3); id_rs = 5'd3; id_uses_rs = 1'b1; id_jump = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if (ctl() !== 8'b00001_001) begin errors++; $display("FAIL mem_freeze%0d got=%b exp=%b", i, ctl(), 8'b00001_001); end
      step();
    end
    clear_inputs();
    mem_req = 1'b1; mem_ready = 1'b1;
    #2;
    checks++;
    if (ctl() !== 8'b11111_000) begin errors++; $display("FAIL mem_done got=%b exp=%b", ctl(), 8'b11111_000); end
    step();
    checks++;
    if (stall_cnt !== 3'd3) begin errors++; $display("FAIL mem_stall_cnt got=%0d exp=3", stall_cnt); end
    mem_req = 1'b1; mem_ready = 1'b0;
    step();
    mem_req = 1'b0;
    #2;
    checks++;
    if (ctl() !== 8'b11111_000) begin errors++; $display("FAIL mem_req_drop got=%b exp=%b", ctl(), 8'b11111_000); end
    step();
    mem_req = 1'b1;
    #2;
    checks++;
    if (ctl() !== 8'b00001_001 || tmo_err !== 1'b0) begin errors++; $display("FAIL mem_rerun got=%b tmo=%b exp=%b tmo=0", ctl(), tmo_err, 8'b00001_001); end
    mem_req = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i <= MEM_TMO; i++) begin
      #2;
      checks++;
      if (ctl() !== 8'b00001_001 || tmo_err !== 1'b0) begin errors++; $display("FAIL tmo_wait%0d got=%b tmo=%b exp=%b tmo=0", i, ctl(), tmo_err, 8'b00001_001); end
      step();
    end
    checks++;
    if (ctl() !== 8'b00000_000 || tmo_err !== 1'b1) begin errors++; $display("FAIL tmo_err got=%b tmo=%b exp=%b tmo=1", ctl(), tmo_err, 8'b00000_000); end
    clear_inputs();
    id_jump = 1'b1;
    step(); step();
    checks++;
    if (ctl() !== 8'b00000_000 || tmo_err !== 1'b1 || stall_cnt !== 3'd7) begin
      errors++; $display("FAIL tmo_sticky got=%b tmo=%b st=%0d exp=%b tmo=1 st=7", ctl(), tmo_err, stall_cnt, 8'b00000_000);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    step(); step();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (ctl() !== 8'b11111_000 || tmo_err !== 1'b0 || stall_cnt !== 3'd0) begin
      errors++; $display("FAIL reset_mid_wait got=%b tmo=%b st=%0d exp=%b tmo=0 st=0", ctl(), tmo_err, stall_cnt, 8'b11111_000);
    end
    step();
    reset = 1'b1;
    #2;
    checks++;
    if (ctl() !== 8'b00001_001) begin errors++; $display("FAIL reset_mid_rerun got=%b exp=%b", ctl(), 8'b00001_001); end
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    set_load(5'd12); id_rt = 5'd12; id_uses_rt = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (stall_cnt !== ((i > 7) ? 3'd7 : 3'(i))) begin errors++; $display("FAIL sat%0d got=%0d exp=%0d", i, stall_cnt, (i > 7) ? 7 : i); end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_jump();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
